// File: rtl/ysyx_25040129_rd_arbiter_pkg.sv
// Shared constants for the IFU/LSU read arbiter: FSM encodings, AXI response codes.
// No logic of its own; the round-robin pick helper is purely combinational.
// Imported by the arbiter and its bench.
package ysyx_25040129_rd_arbiter_pkg;

    localparam logic [1:0] ysyx_25040129_ARB_IDLE    = 2'd0;
    localparam logic [1:0] ysyx_25040129_ARB_GNT_IFU = 2'd1;
    localparam logic [1:0] ysyx_25040129_ARB_GNT_LSU = 2'd2;

    localparam logic [1:0] ysyx_25040129_OKAY = 2'b00;

    // On a tie the master that did not own the port last time wins (last: 0 = IFU, 1 = LSU).
    function automatic logic rr_pick_lsu(input logic ifu_req, input logic lsu_req, input logic last);
        return lsu_req & (~ifu_req | ~last);
    endfunction

endpackage

// File: rtl/ysyx_25040129_rd_arbiter.sv
// Two-master AXI4-Lite read arbiter (IFU/LSU -> one memory read port), grant locked AR..R.
// Latency: 1 arbitration cycle in IDLE, then AR/R paths are combinational pass-through.
// Backpressure: slave arready/rvalid and owner rready pass straight through; non-owner waits.
module ysyx_25040129_rd_arbiter
    import ysyx_25040129_rd_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [ADDR_W-1:0] ifu_araddr,
    input  logic              ifu_arvalid,
    output logic              ifu_arready,
    output logic [DATA_W-1:0] ifu_rdata,
    output logic [1:0]        ifu_rresp,
    output logic              ifu_rvalid,
    input  logic              ifu_rready,

    input  logic [ADDR_W-1:0] lsu_araddr,
    input  logic              lsu_arvalid,
    output logic              lsu_arready,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic [1:0]        lsu_rresp,
    output logic              lsu_rvalid,
    input  logic              lsu_rready,

    output logic [ADDR_W-1:0] mem_araddr,
    output logic              mem_arvalid,
    input  logic              mem_arready,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [1:0]        mem_rresp,
    input  logic              mem_rvalid,
    output logic              mem_rready
);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       ar_done;
    logic       ar_done_nxt;
    logic       last;
    logic       last_nxt;

    logic own_ifu;
    logic own_lsu;
    logic sel_arvalid;
    logic sel_rready;
    logic ar_hs;
    logic r_hs;
    logic data_ok;
    logic fwd_rvalid;

    always_comb begin
        own_ifu     = (state == ysyx_25040129_ARB_GNT_IFU);
        own_lsu     = (state == ysyx_25040129_ARB_GNT_LSU);
        sel_arvalid = (own_ifu & ifu_arvalid) | (own_lsu & lsu_arvalid);
        sel_rready  = (own_ifu & ifu_rready)  | (own_lsu & lsu_rready);

        mem_araddr  = own_lsu ? lsu_araddr : ifu_araddr;
        mem_arvalid = rst & sel_arvalid & ~ar_done;
        ar_hs       = mem_arvalid & mem_arready;

        // Read data is only meaningful once the address went out (earlier or this very cycle).
        data_ok     = ar_done | ar_hs;
        mem_rready  = rst & sel_rready & data_ok;
        fwd_rvalid  = rst & mem_rvalid & data_ok;
        r_hs        = mem_rvalid & mem_rready;

        ifu_arready = rst & own_ifu & mem_arready & ~ar_done;
        lsu_arready = rst & own_lsu & mem_arready & ~ar_done;
        ifu_rvalid  = own_ifu & fwd_rvalid;
        lsu_rvalid  = own_lsu & fwd_rvalid;

        ifu_rdata   = mem_rdata;
        ifu_rresp   = mem_rresp;
        lsu_rdata   = mem_rdata;
        lsu_rresp   = mem_rresp;
    end

    always_comb begin
        state_nxt   = state;
        ar_done_nxt = ar_done;
        last_nxt    = last;
        case (state)
            ysyx_25040129_ARB_IDLE: begin
                if (ifu_arvalid | lsu_arvalid) begin
                    state_nxt = rr_pick_lsu(ifu_arvalid, lsu_arvalid, last) ?
                                ysyx_25040129_ARB_GNT_LSU : ysyx_25040129_ARB_GNT_IFU;
                end
            end
            ysyx_25040129_ARB_GNT_IFU, ysyx_25040129_ARB_GNT_LSU: begin
                if (r_hs) begin
                    state_nxt   = ysyx_25040129_ARB_IDLE;
                    ar_done_nxt = 1'b0;
                    last_nxt    = own_lsu;
                end else if (ar_hs) begin
                    ar_done_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt   = ysyx_25040129_ARB_IDLE;
                ar_done_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= ysyx_25040129_ARB_IDLE;
            ar_done <= 1'b0;
            last    <= 1'b0;
        end else begin
            state   <= state_nxt;
            ar_done <= ar_done_nxt;
            last    <= last_nxt;
        end
    end

endmodule

// File: tb/tb_ysyx_25040129_rd_arbiter.sv
// Directed bench for the IFU/LSU read arbiter; the slave side is driven by the scenario tasks.
// Inputs change on the falling edge, outputs are sampled 1 time unit later.
// Backpressure cases: delayed rvalid, pending non-owner, error responses, mid-transaction reset.
module tb_ysyx_25040129_rd_arbiter;
    import ysyx_25040129_rd_arbiter_pkg::*;

    logic        clk;
    logic        rst;
    logic [31:0] ifu_araddr;
    logic        ifu_arvalid;
    logic        ifu_arready;
    logic [31:0] ifu_rdata;
    logic [1:0]  ifu_rresp;
    logic        ifu_rvalid;
    logic        ifu_rready;
    logic [31:0] lsu_araddr;
    logic        lsu_arvalid;
    logic        lsu_arready;
    logic [31:0] lsu_rdata;
    logic [1:0]  lsu_rresp;
    logic        lsu_rvalid;
    logic        lsu_rready;
    logic [31:0] mem_araddr;
    logic        mem_arvalid;
    logic        mem_arready;
    logic [31:0] mem_rdata;
    logic [1:0]  mem_rresp;
    logic        mem_rvalid;
    logic        mem_rready;

    int checks = 0;
    int errors = 0;

    ysyx_25040129_rd_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
        .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
        .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
        .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
        .mem_araddr(mem_araddr), .mem_arvalid(mem_arvalid), .mem_arready(mem_arready),
        .mem_rdata(mem_rdata), .mem_rresp(mem_rresp), .mem_rvalid(mem_rvalid), .mem_rready(mem_rready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic quiet();
        ifu_arvalid = 1'b0; ifu_rready = 1'b0;
        lsu_arvalid = 1'b0; lsu_rready = 1'b0;
        mem_arready = 1'b0; mem_rvalid = 1'b0;
        mem_rdata   = 32'h0; mem_rresp = ysyx_25040129_OKAY;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        ifu_araddr = 32'h3000_0000; ifu_arvalid = 1'b1; ifu_rready = 1'b1;
        lsu_araddr = 32'h8000_1000; lsu_arvalid = 1'b1; lsu_rready = 1'b1;
        mem_arready = 1'b1; mem_rvalid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            checks++; if ({ifu_arready, lsu_arready} !== 2'b00) begin errors++; $display("FAIL reset_arready: got %b want 00", {ifu_arready, lsu_arready}); end
            checks++; if ({ifu_rvalid, lsu_rvalid} !== 2'b00) begin errors++; $display("FAIL reset_rvalid: got %b want 00", {ifu_rvalid, lsu_rvalid}); end
            checks++; if ({mem_arvalid, mem_rready} !== 2'b00) begin errors++; $display("FAIL reset_mem: got %b want 00", {mem_arvalid, mem_rready}); end
        end
        @(negedge clk);
        rst = 1'b1; mem_arready = 1'b0; mem_rvalid = 1'b0;
        #1;
        checks++; if (mem_arvalid !== 1'b0) begin errors++; $display("FAIL reset_idle_arb: mem_arvalid got %b want 0", mem_arvalid); end
        @(negedge clk); #1;
        checks++; if (mem_arvalid !== 1'b1) begin errors++; $display("FAIL first_grant_vld: got %b want 1", mem_arvalid); end
        checks++; if (mem_araddr !== 32'h8000_1000) begin errors++; $display("FAIL first_grant_lsu: mem_araddr got %h want 80001000", mem_araddr); end
        checks++; if ({ifu_arready, lsu_arready} !== 2'b00) begin errors++; $display("FAIL first_grant_arready: got %b want 00", {ifu_arready, lsu_arready}); end
        mem_arready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_0001;
        #1;
        checks++; if ({lsu_arready, lsu_rvalid, ifu_rvalid} !== 3'b110) begin errors++; $display("FAIL first_grant_done: got %b want 110", {lsu_arready, lsu_rvalid, ifu_rvalid}); end
        checks++; if (lsu_rdata !== 32'hCAFE_0001) begin errors++; $display("FAIL first_grant_data: got %h want cafe0001", lsu_rdata); end
        @(negedge clk);
        quiet();
        @(negedge clk);
    endtask

    task automatic test_ifu_alone();
        ifu_arvalid = 1'b1; ifu_araddr = 32'h3000_0000; ifu_rready = 1'b1;
        #1;
        checks++; if (mem_arvalid !== 1'b0) begin errors++; $display("FAIL ifu_arb_cycle: mem_arvalid got %b want 0", mem_arvalid); end
        @(negedge clk); #1;
        checks++; if (mem_arvalid !== 1'b1 || mem_araddr !== 32'h3000_0000) begin errors++; $display("FAIL ifu_grant: vld %b addr %h want 1 30000000", mem_arvalid, mem_araddr); end
        mem_arready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0413; mem_rresp = ysyx_25040129_OKAY;
        #1;
        checks++; if ({ifu_arready, ifu_rvalid, mem_rready, lsu_rvalid} !== 4'b1110) begin errors++; $display("FAIL ifu_fast_path: got %b want 1110", {ifu_arready, ifu_rvalid, mem_rready, lsu_rvalid}); end
        checks++; if (ifu_rdata !== 32'h0000_0413 || ifu_rresp !== ysyx_25040129_OKAY) begin errors++; $display("FAIL ifu_fast_data: got %h/%b want 00000413/00", ifu_rdata, ifu_rresp); end
        @(negedge clk);
        quiet();
        #1;
        checks++; if (mem_arvalid !== 1'b0) begin errors++; $display("FAIL ifu_back_idle: mem_arvalid got %b want 0", mem_arvalid); end
    endtask

    task automatic test_delayed_r();
        @(negedge clk);
        ifu_arvalid = 1'b1; ifu_araddr = 32'h3000_0004; ifu_rready = 1'b1; mem_arready = 1'b1;
        #1;
        checks++; if (ifu_arready !== 1'b0) begin errors++; $display("FAIL delay_idle_arready: got %b want 0", ifu_arready); end
        @(negedge clk);
        lsu_arvalid = 1'b1; lsu_araddr = 32'h8000_2000; lsu_rready = 1'b1;
        #1;
        checks++; if ({mem_arvalid, ifu_arready, lsu_arready} !== 3'b110) begin errors++; $display("FAIL delay_ar_hs: got %b want 110", {mem_arvalid, ifu_arready, lsu_arready}); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            checks++; if ({mem_arvalid, ifu_arready, lsu_arready, ifu_rvalid} !== 4'b0000) begin errors++; $display("FAIL delay_wait%0d: got %b want 0000", i, {mem_arvalid, ifu_arready, lsu_arready, ifu_rvalid}); end
        end
        @(negedge clk);
        ifu_arvalid = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        #1;
        checks++; if ({ifu_rvalid, mem_rready, lsu_rvalid, lsu_arready} !== 4'b1100) begin errors++; $display("FAIL delay_r_hs: got %b want 1100", {ifu_rvalid, mem_rready, lsu_rvalid, lsu_arready}); end
        checks++; if (ifu_rdata !== 32'h1234_5678) begin errors++; $display("FAIL delay_data: got %h want 12345678", ifu_rdata); end
        @(negedge clk);
        mem_rvalid = 1'b0; mem_arready = 1'b0;
        #1;
        checks++; if (mem_arvalid !== 1'b0) begin errors++; $display("FAIL delay_idle_gap: mem_arvalid got %b want 0", mem_arvalid); end
        @(negedge clk); #1;
        checks++; if (mem_arvalid !== 1'b1 || mem_araddr !== 32'h8000_2000) begin errors++; $display("FAIL pending_lsu: vld %b addr %h want 1 80002000", mem_arvalid, mem_araddr); end
        mem_arready = 1'b1; mem_rvalid = 1'b1;
        #1;
        checks++; if (lsu_rvalid !== 1'b1) begin errors++; $display("FAIL pending_lsu_done: lsu_rvalid got %b want 1", lsu_rvalid); end
        @(negedge clk);
        quiet();
    endtask

    task automatic test_spurious();
        @(negedge clk);
        mem_rvalid = 1'b1; ifu_rready = 1'b1; ifu_arvalid = 1'b1; ifu_araddr = 32'h3000_0020;
        #1;
        checks++; if ({ifu_rvalid, lsu_rvalid, mem_rready} !== 3'b000) begin errors++; $display("FAIL spurious_idle: got %b want 000", {ifu_rvalid, lsu_rvalid, mem_rready}); end
        @(negedge clk); #1;
        checks++; if ({mem_arvalid, ifu_rvalid, mem_rready} !== 3'b100) begin errors++; $display("FAIL spurious_pre_ar: got %b want 100", {mem_arvalid, ifu_rvalid, mem_rready}); end
        mem_arready = 1'b1;
        #1;
        checks++; if ({ifu_rvalid, mem_rready} !== 2'b11) begin errors++; $display("FAIL spurious_same_cycle: got %b want 11", {ifu_rvalid, mem_rready}); end
        @(negedge clk);
        quiet();
    endtask

    task automatic test_back_to_back();
        int  idle;
        bit  found;
        bit  exp_lsu;
        @(negedge clk);
        ifu_arvalid = 1'b1; ifu_araddr = 32'h3000_0100; ifu_rready = 1'b1;
        lsu_arvalid = 1'b1; lsu_araddr = 32'h8000_0100; lsu_rready = 1'b1;
        #1;
        for (int i = 0; i < 6; i++) begin
            exp_lsu = (i % 2 == 0);
            idle = 0; found = 1'b0;
            for (int c = 0; c < 6 && !found; c++) begin
                @(negedge clk);
                mem_arready = 1'b0; mem_rvalid = 1'b0;
                #1;
                if (mem_arvalid) found = 1'b1; else idle++;
            end
            checks++; if (!found) begin errors++; $display("FAIL rr_timeout%0d: no grant within 6 cycles", i); end
            if (i > 0) begin
                checks++; if (idle != 1) begin errors++; $display("FAIL rr_gap%0d: idle cycles %0d want 1", i, idle); end
            end
            checks++; if (mem_araddr !== (exp_lsu ? 32'h8000_0100 : 32'h3000_0100)) begin errors++; $display("FAIL rr_order%0d: addr %h want %h", i, mem_araddr, exp_lsu ? 32'h8000_0100 : 32'h3000_0100); end
            mem_arready = 1'b1; mem_rvalid = 1'b1; mem_rdata = i;
            #1;
            checks++; if ({lsu_rvalid, ifu_rvalid} !== (exp_lsu ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rr_rvalid%0d: got %b want %b", i, {lsu_rvalid, ifu_rvalid}, exp_lsu ? 2'b10 : 2'b01); end
        end
        @(negedge clk);
        quiet();
    endtask

    task automatic test_error_resp();
        @(negedge clk);
        lsu_arvalid = 1'b1; lsu_araddr = 32'h8000_3000; lsu_rready = 1'b1;
        @(negedge clk); #1;
        checks++; if (mem_arvalid !== 1'b1 || mem_araddr !== 32'h8000_3000) begin errors++; $display("FAIL err_grant: vld %b addr %h want 1 80003000", mem_arvalid, mem_araddr); end
        mem_arready = 1'b1;
        @(negedge clk);
        mem_arready = 1'b0; lsu_arvalid = 1'b0; mem_rvalid = 1'b1; mem_rresp = 2'b10;
        #1;
        checks++; if (lsu_rvalid !== 1'b1 || lsu_rresp !== 2'b10) begin errors++; $display("FAIL err_resp: rvalid %b rresp %b want 1 10", lsu_rvalid, lsu_rresp); end
        @(negedge clk);
        mem_rvalid = 1'b0; mem_rresp = ysyx_25040129_OKAY;
        ifu_arvalid = 1'b1; ifu_araddr = 32'h3000_0008; ifu_rready = 1'b1;
        #1;
        checks++; if (mem_arvalid !== 1'b0) begin errors++; $display("FAIL err_idle: mem_arvalid got %b want 0", mem_arvalid); end
        @(negedge clk); #1;
        checks++; if (mem_arvalid !== 1'b1 || mem_araddr !== 32'h3000_0008) begin errors++; $display("FAIL err_next_ifu: vld %b addr %h want 1 30000008", mem_arvalid, mem_araddr); end
        mem_arready = 1'b1; mem_rvalid = 1'b1;
        #1;
        checks++; if (ifu_rvalid !== 1'b1 || ifu_rresp !== ysyx_25040129_OKAY) begin errors++; $display("FAIL err_next_done: rvalid %b rresp %b want 1 00", ifu_rvalid, ifu_rresp); end
        @(negedge clk);
        quiet();
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        ifu_arvalid = 1'b1; ifu_araddr = 32'h3000_000C; ifu_rready = 1'b1;
        @(negedge clk);
        mem_arready = 1'b1;
        #1;
        checks++; if (ifu_arready !== 1'b1) begin errors++; $display("FAIL mid_ar_hs: ifu_arready got %b want 1", ifu_arready); end
        @(negedge clk);
        mem_arready = 1'b0; ifu_arvalid = 1'b0;
        #1;
        checks++; if (mem_arvalid !== 1'b0) begin errors++; $display("FAIL mid_ar_done: mem_arvalid got %b want 0", mem_arvalid); end
        rst = 1'b0; mem_rvalid = 1'b1;
        #1;
        checks++; if ({ifu_rvalid, mem_rready} !== 2'b00) begin errors++; $display("FAIL mid_in_reset: got %b want 00", {ifu_rvalid, mem_rready}); end
        @(negedge clk);
        rst = 1'b1; ifu_arvalid = 1'b1; ifu_araddr = 32'h3000_0010;
        #1;
        checks++; if ({ifu_rvalid, mem_rready, mem_arvalid} !== 3'b000) begin errors++; $display("FAIL mid_after_reset: got %b want 000", {ifu_rvalid, mem_rready, mem_arvalid}); end
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        checks++; if (mem_arvalid !== 1'b1 || mem_araddr !== 32'h3000_0010) begin errors++; $display("FAIL mid_restart: vld %b addr %h want 1 30000010", mem_arvalid, mem_araddr); end
        mem_arready = 1'b1; mem_rvalid = 1'b1;
        #1;
        checks++; if ({ifu_arready, ifu_rvalid} !== 2'b11) begin errors++; $display("FAIL mid_restart_done: got %b want 11", {ifu_arready, ifu_rvalid}); end
        @(negedge clk);
        quiet();
    endtask

    initial begin
        rst = 1'b0;
        ifu_araddr = 32'h0; lsu_araddr = 32'h0;
        quiet();
        test_reset();
        test_ifu_alone();
        test_delayed_r();
        test_spurious();
        test_back_to_back();
        test_error_resp();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
